// File: rtl/sound_player.sv
// Sound-request consumer: synchronises the slow-domain {channel, sound} request and
// plays it as 1-bit square waves on the left/right audio pins.
//   clk     : system clock
//   reset   : asynchronous active-low reset
//   channel : 0 none, 1 right, 2 left, 3 both (slow clock domain)
//   sound   : 0 silence, 1 ping, 2 pong, 3 goal warble (slow clock domain)
//   audio_l : left speaker square wave
//   audio_r : right speaker square wave
//   busy    : high while a tone is playing
module sound_player #(
  parameter int unsigned PING_HALF   = 28409,
  parameter int unsigned PONG_HALF   = 14205,
  parameter int unsigned GOAL_HALF_A = 56818,
  parameter int unsigned GOAL_HALF_B = 37879,
  parameter int unsigned WARBLE_CYC  = 1250000,
  parameter int unsigned MAX_CYC     = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] channel,
  input  logic [1:0] sound,
  output logic       audio_l,
  output logic       audio_r,
  output logic       busy
);

  localparam int unsigned HALF_M1  = (PING_HALF > PONG_HALF) ? PING_HALF : PONG_HALF;
  localparam int unsigned HALF_M2  = (GOAL_HALF_A > GOAL_HALF_B) ? GOAL_HALF_A : GOAL_HALF_B;
  localparam int unsigned HALF_MAX = (HALF_M1 > HALF_M2) ? HALF_M1 : HALF_M2;
  localparam int unsigned PW       = $clog2(HALF_MAX + 1);
  localparam int unsigned WW       = $clog2(WARBLE_CYC + 1);
  localparam int unsigned DW       = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TONE    = 2'd1,
    S_TIMEOUT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      ch_m_q, ch_s_q, snd_m_q, snd_s_q;
  logic [1:0]      ch_lat_q, ch_lat_d, snd_lat_q, snd_lat_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic            sq_q, sq_d;
  logic [WW-1:0]   warble_q, warble_d;
  logic            wsel_q, wsel_d;
  logic [DW-1:0]   dur_q, dur_d;
  logic            audio_l_q, audio_l_d, audio_r_q, audio_r_d, busy_q, busy_d;

  logic            req_valid;
  logic            capture;
  logic            is_goal;
  logic [PW-1:0]   half;

  // Next-state and output decode
  always_comb begin
    state_d   = state_q;
    ch_lat_d  = ch_lat_q;
    snd_lat_d = snd_lat_q;
    phase_d   = phase_q;
    sq_d      = sq_q;
    warble_d  = warble_q;
    wsel_d    = wsel_q;
    dur_d     = dur_q;

    req_valid = (ch_s_q != 2'd0) && (snd_s_q != 2'd0);
    capture   = req_valid &&
                ((state_q == S_IDLE) || ({ch_s_q, snd_s_q} != {ch_lat_q, snd_lat_q}));
    is_goal   = (snd_lat_q == 2'd3);

    unique case (snd_lat_q)
      2'd2:    half = PW'(PONG_HALF);
      2'd3:    half = wsel_q ? PW'(GOAL_HALF_B) : PW'(GOAL_HALF_A);
      default: half = PW'(PING_HALF);
    endcase

    if (capture) begin
      // A fresh request (or a changed one mid-tone) always restarts from a clean phase
      state_d   = S_TONE;
      ch_lat_d  = ch_s_q;
      snd_lat_d = snd_s_q;
      phase_d   = '0;
      sq_d      = 1'b0;
      warble_d  = '0;
      wsel_d    = 1'b0;
      dur_d     = '0;
    end else begin
      unique case (state_q)
        S_TONE: begin
          if (!req_valid) begin
            state_d = S_IDLE;
          end else begin
            // Warble segment boundary wins over a half-period toggle; sq holds its level
            if (is_goal && (warble_q == WW'(WARBLE_CYC - 1))) begin
              warble_d = '0;
              wsel_d   = ~wsel_q;
              phase_d  = '0;
            end else begin
              if (is_goal) warble_d = warble_q + WW'(1);
              if (phase_q == half - PW'(1)) begin
                phase_d = '0;
                sq_d    = ~sq_q;
              end else begin
                phase_d = phase_q + PW'(1);
              end
            end
            if (dur_q == DW'(MAX_CYC - 1)) state_d = S_TIMEOUT;
            else                           dur_d   = dur_q + DW'(1);
          end
        end
        S_TIMEOUT: begin
          if (!req_valid) state_d = S_IDLE;
        end
        S_IDLE: begin
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d    = (state_d == S_TONE);
    audio_l_d = sq_d & ch_lat_d[1] & busy_d;
    audio_r_d = sq_d & ch_lat_d[0] & busy_d;
  end

  // State, synchroniser and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ch_m_q    <= '0;
      ch_s_q    <= '0;
      snd_m_q   <= '0;
      snd_s_q   <= '0;
      ch_lat_q  <= '0;
      snd_lat_q <= '0;
      phase_q   <= '0;
      sq_q      <= 1'b0;
      warble_q  <= '0;
      wsel_q    <= 1'b0;
      dur_q     <= '0;
      audio_l_q <= 1'b0;
      audio_r_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_m_q    <= channel;
      ch_s_q    <= ch_m_q;
      snd_m_q   <= sound;
      snd_s_q   <= snd_m_q;
      ch_lat_q  <= ch_lat_d;
      snd_lat_q <= snd_lat_d;
      phase_q   <= phase_d;
      sq_q      <= sq_d;
      warble_q  <= warble_d;
      wsel_q    <= wsel_d;
      dur_q     <= dur_d;
      audio_l_q <= audio_l_d;
      audio_r_q <= audio_r_d;
      busy_q    <= busy_d;
    end
  end

  assign audio_l = audio_l_q;
  assign audio_r = audio_r_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_sound_player.sv
// Bench for sound_player: directed scenarios plus randomized requests, checked every
// cycle against a closed-form model of the tone produced since the last capture.
module tb_sound_player;

  localparam int PING = 4;
  localparam int PONG = 2;
  localparam int GA   = 6;
  localparam int GB   = 3;
  localparam int WC   = 24;
  localparam int MAXC = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] channel = 2'd0;
  logic [1:0] sound = 2'd0;
  logic       audio_l, audio_r, busy;

  int checks = 0;
  int errors = 0;

  sound_player #(
    .PING_HALF(PING), .PONG_HALF(PONG), .GOAL_HALF_A(GA), .GOAL_HALF_B(GB),
    .WARBLE_CYC(WC), .MAX_CYC(MAXC)
  ) dut (
    .clk(clk), .reset(reset), .channel(channel), .sound(sound),
    .audio_l(audio_l), .audio_r(audio_r), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Square-wave level t cycles after capture, from the tone rules
  function automatic logic sq_at(input int t_in, input int snd);
    int t, h, k;
    logic s;
    t = t_in;
    s = 1'b0;
    if (snd == 3) begin
      k = 0;
      while (t >= WC) begin
        h = (k % 2 == 1) ? GB : GA;
        // toggles within a full segment happen at multiples of h strictly below WC
        s ^= logic'(((WC - 1) / h) % 2);
        t -= WC;
        k++;
      end
      h = (k % 2 == 1) ? GB : GA;
      s ^= logic'((t / h) % 2);
    end else begin
      h = (snd == 1) ? PING : PONG;
      s = logic'((t / h) % 2);
    end
    return s;
  endfunction

  // Reference model: request seen two edges late, mode 0 idle / 1 playing / 2 timed out
  logic [1:0] m_d1_ch = 0, m_d1_snd = 0, m_d2_ch = 0, m_d2_snd = 0;
  logic [1:0] m_lat_ch = 0, m_lat_snd = 0;
  int         m_mode = 0;
  int         m_t = 0;

  always @(posedge clk or negedge reset) begin
    logic [1:0] r_ch, r_snd;
    logic       valid;
    if (!reset) begin
      m_d1_ch = 0; m_d1_snd = 0; m_d2_ch = 0; m_d2_snd = 0;
      m_lat_ch = 0; m_lat_snd = 0; m_mode = 0; m_t = 0;
    end else begin
      r_ch = m_d2_ch; r_snd = m_d2_snd;
      m_d2_ch = m_d1_ch; m_d2_snd = m_d1_snd;
      m_d1_ch = channel; m_d1_snd = sound;
      valid = (r_ch != 0) && (r_snd != 0);
      if (valid && (m_mode == 0 || r_ch != m_lat_ch || r_snd != m_lat_snd)) begin
        m_lat_ch = r_ch; m_lat_snd = r_snd; m_mode = 1; m_t = 0;
      end else if (!valid) begin
        m_mode = 0;
      end else if (m_mode == 1) begin
        m_t++;
        if (m_t >= MAXC) m_mode = 2;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    logic eb, es;
    eb = (m_mode == 1);
    es = eb && sq_at(m_t, int'(m_lat_snd));
    check("model_busy", busy, eb);
    check("model_audio_l", audio_l, es & m_lat_ch[1]);
    check("model_audio_r", audio_r, es & m_lat_ch[0]);
  end

  task automatic drive(input logic [1:0] ch, input logic [1:0] snd, input int cyc);
    @(negedge clk);
    channel = ch;
    sound   = snd;
    repeat (cyc) @(posedge clk);
  endtask

  initial begin
    logic [12:1] busy_pat, aud_pat;
    bit found;
    busy_pat = 12'b1111_1111_1100;
    aud_pat  = 12'b0011_1100_0000;

    #3;
    check("reset_audio_l", audio_l, 1'b0);
    check("reset_audio_r", audio_r, 1'b0);
    check("reset_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);

    // 1: both channels, ping; capture at edge 3, first rise at edge 7
    @(negedge clk);
    channel = 2'd3; sound = 2'd1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      check("t1_busy", busy, busy_pat[e]);
      check("t1_audio_l", audio_l, aud_pat[e]);
      check("t1_audio_r", audio_r, aud_pat[e]);
    end

    // 2: left only, pong; then release drops everything on the 3rd edge
    drive(2'd2, 2'd2, 20);
    @(negedge clk);
    channel = 2'd0;
    @(posedge clk); #1 check("t2_rel_e1", busy, 1'b1);
    @(posedge clk); #1 check("t2_rel_e2", busy, 1'b1);
    @(posedge clk); #1 check("t2_rel_e3", busy, 1'b0);
    check("t2_rel_audio", audio_l, 1'b0);
    repeat (4) @(posedge clk);

    // 3: right only, goal warble
    drive(2'd1, 2'd3, 110);
    // 4: ping then switch to pong on the same channel
    drive(2'd3, 2'd1, 15);
    drive(2'd3, 2'd2, 20);
    drive(2'd0, 2'd0, 6);

    // 5: timeout after 100 cycles in TONE, replay after release
    @(negedge clk);
    channel = 2'd3; sound = 2'd1;
    repeat (3) @(posedge clk);
    #1 check("t5_capture", busy, 1'b1);
    repeat (99) @(posedge clk);
    #1 check("t5_last_tone", busy, 1'b1);
    @(posedge clk);
    #1 check("t5_timeout", busy, 1'b0);
    check("t5_timeout_l", audio_l, 1'b0);
    repeat (47) @(posedge clk);
    #1 check("t5_held", busy, 1'b0);
    drive(2'd0, 2'd0, 6);
    #1 check("t5_idle", busy, 1'b0);
    @(negedge clk);
    channel = 2'd3; sound = 2'd1;
    repeat (3) @(posedge clk);
    #1 check("t5_replay", busy, 1'b1);
    repeat (10) @(posedge clk);

    // 6: asynchronous reset in the middle of a goal tone
    drive(2'd1, 2'd3, 5);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk); #1;
      if (audio_r) found = 1'b1;
    end
    check("t6_tone_high", audio_r, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("t6_async_r", audio_r, 1'b0);
    check("t6_async_busy", busy, 1'b0);
    channel = 2'd0; sound = 2'd0;
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("t6_idle", busy, 1'b0);
    drive(2'd3, 2'd0, 10);
    #1 check("t6_silence", busy, 1'b0);
    check("t6_silence_l", audio_l, 1'b0);

    // Randomized requests with occasional reset pulses
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
      end
      drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom_range(1, 130));
    end
    drive(2'd0, 2'd0, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
